// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state encoding for the TDM demultiplexer
package tdm_pkg;

  localparam int NLANES = 8;
  localparam int W      = 16;
  localparam int SLOT_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux8x16_if.sv
// rtl/tdm_demux8x16_if.sv - serial input stream and demultiplexed frame output bundle
interface tdm_demux8x16_if #(
  parameter int W = tdm_pkg::W
) ();

  logic [W-1:0] in;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] e;
  logic [W-1:0] f;
  logic [W-1:0] g;
  logic [W-1:0] h;
  logic         out_valid;
  logic         out_ack;
  logic         err;

  // Producer/consumer side: drives the stream and the frame acknowledge
  modport master (
    output in, in_valid, in_sof, out_ack,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, err
  );

  // Demultiplexer side
  modport slave (
    input  in, in_valid, in_sof, out_ack,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, err
  );

endinterface

// File: rtl/DMux8Way.sv
// rtl/DMux8Way.sv - 1-to-8 demultiplexer gate routing one bit to the selected output
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

// File: rtl/tdm_lane_reg.sv
// rtl/tdm_lane_reg.sv - W-bit lane register with load enable and async reset
module tdm_lane_reg #(
  parameter int W = tdm_pkg::W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the word until load is asserted; reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/tdm_demux8x16.sv
// rtl/tdm_demux8x16.sv - collects 8 serial words into a frame and presents them as parallel lanes
module tdm_demux8x16
  import tdm_pkg::SLOT_W, tdm_pkg::state_t, tdm_pkg::IDLE, tdm_pkg::COLLECT;
#(
  parameter int NLANES = tdm_pkg::NLANES,
  parameter int W      = tdm_pkg::W
) (
  input  logic            clock,
  input  logic            reset,
  tdm_demux8x16_if.slave  bus
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NLANES - 1);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] wr_slot;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              in_ready;
  logic              accept;
  logic              shadow_we;
  logic              deliver;
  logic [7:0]        shadow_ld;

  logic [W-1:0] shadow [NLANES];
  logic [W-1:0] lane_q [NLANES];
  logic [W-1:0] lane_d [NLANES];

  // Stall only the final beat of a frame while the previous frame is still unacknowledged
  assign in_ready = !((state_q == COLLECT) && (slot_q == LAST) && out_valid_q && !bus.out_ack);
  assign accept   = bus.in_valid && in_ready;

  // Next-state, slot and control decode for the IDLE/COLLECT machine
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wr_slot     = slot_q;
    shadow_we   = 1'b0;
    deliver     = 1'b0;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;

    if (bus.out_ack) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_sof) begin
            shadow_we = 1'b1;
            wr_slot   = '0;
            slot_d    = SLOT_W'(1);
            state_d   = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (bus.in_sof) begin
            // A new frame start abandons whatever was partially collected
            err_d     = (slot_q != '0);
            shadow_we = 1'b1;
            wr_slot   = '0;
            slot_d    = SLOT_W'(1);
          end else if (slot_q == LAST) begin
            shadow_we   = 1'b1;
            deliver     = 1'b1;
            out_valid_d = 1'b1;
            slot_d      = '0;
            state_d     = IDLE;
          end else begin
            shadow_we = 1'b1;
            slot_d    = slot_q + SLOT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  DMux8Way u_slot_dec (
    .in  (shadow_we),
    .sel (wr_slot),
    .a   (shadow_ld[0]),
    .b   (shadow_ld[1]),
    .c   (shadow_ld[2]),
    .d   (shadow_ld[3]),
    .e   (shadow_ld[4]),
    .f   (shadow_ld[5]),
    .g   (shadow_ld[6]),
    .h   (shadow_ld[7])
  );

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    // The word being written this edge bypasses its shadow slot so delivery needs no extra cycle
    assign lane_d[i] = (slot_q == SLOT_W'(i)) ? bus.in : shadow[i];

    tdm_lane_reg #(.W(W)) u_shadow (
      .clock (clock),
      .reset (reset),
      .load  (shadow_ld[i]),
      .d     (bus.in),
      .q     (shadow[i])
    );

    tdm_lane_reg #(.W(W)) u_out (
      .clock (clock),
      .reset (reset),
      .load  (deliver),
      .d     (lane_d[i]),
      .q     (lane_q[i])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.a         = lane_q[0];
  assign bus.b         = lane_q[1];
  assign bus.c         = lane_q[2];
  assign bus.d         = lane_q[3];
  assign bus.e         = lane_q[4];
  assign bus.f         = lane_q[5];
  assign bus.g         = lane_q[6];
  assign bus.h         = lane_q[7];

endmodule

// File: tb/tb_tdm_demux8x16.sv
// tb/tb_tdm_demux8x16.sv - scoreboard bench for the 8x16 TDM demultiplexer
module tb_tdm_demux8x16;

  logic clock = 1'b0;
  logic reset;

  tdm_demux8x16_if bus ();

  tdm_demux8x16 #(.NLANES(8), .W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int err_cnt = 0;
  logic [127:0] sb [$];

  // Count err pulses shortly after each rising edge
  always @(posedge clock) begin
    #2;
    if (bus.err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [127:0] lanes();
    return {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  endfunction

  function automatic logic [127:0] pack(input logic [15:0] w [8]);
    logic [127:0] p;
    for (int i = 0; i < 8; i++) p[i*16 +: 16] = w[i];
    return p;
  endfunction

  // Drive one beat at a falling edge, wait for acceptance, return at the next falling edge
  task automatic send_beat(input logic [15:0] d, input logic sof);
    int n;
    n = 0;
    bus.in       = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n == 40) chk("ready_timeout", 0, 1);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w [8], input bit gapped);
    sb.push_back(pack(w));
    for (int i = 0; i < 8; i++) begin
      send_beat(w[i], i == 0);
      if (gapped && i < 7) @(negedge clock);
    end
  endtask

  task automatic expect_frame(input string tag);
    logic [127:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_lanes"}, lanes(), exp);
    end
  endtask

  task automatic ack();
    bus.out_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ack = 1'b0;
  endtask

  logic [15:0] w [8];
  logic [15:0] w2 [8];
  logic [127:0] held;
  int e0;

  initial begin
    bus.in       = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.out_ack  = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_lanes", lanes(), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1);

    // Nominal back-to-back frame
    e0 = err_cnt;
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    send_frame(w, 1'b0);
    expect_frame("nominal");
    chk("nominal_err", err_cnt - e0, 0);
    ack();
    chk("ack_clears", bus.out_valid, 0);
    ack();
    chk("idle_ack_ignored", bus.out_valid, 0);
    chk("idle_ack_lanes", lanes(), pack(w));

    // Backpressure: frame 1 unacked, frame 2 stalls on its last beat
    for (int i = 0; i < 8; i++) w[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 8; i++) w2[i] = 16'h2000 + 16'(i);
    send_frame(w, 1'b0);
    expect_frame("bp_frame1");
    sb.push_back(pack(w2));
    for (int i = 0; i < 7; i++) send_beat(w2[i], i == 0);
    bus.in       = w2[7];
    bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", bus.in_ready, 0);
    @(negedge clock);
    chk("bp_still_stalled", bus.in_ready, 0);
    chk("bp_lanes_stable", lanes(), pack(w));
    bus.out_ack = 1'b1;
    #1;
    chk("bp_ready_on_ack", bus.in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    bus.out_ack  = 1'b0;
    bus.in_valid = 1'b0;
    expect_frame("bp_frame2");
    ack();

    // sof in the middle of a frame
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send_beat(16'h3000 + 16'(i), i == 0);
    send_beat(16'hAAAA, 1'b1);
    w[0] = 16'hAAAA;
    for (int i = 1; i < 8; i++) w[i] = 16'hB000 + 16'(i);
    sb.push_back(pack(w));
    for (int i = 1; i < 7; i++) send_beat(w[i], 1'b0);
    chk("midsof_no_partial", bus.out_valid, 0);
    send_beat(w[7], 1'b0);
    expect_frame("midsof");
    chk("midsof_err_once", err_cnt - e0, 1);
    ack();

    // Stray beat while idle
    e0 = err_cnt;
    send_beat(16'hDEAD, 1'b0);
    chk("stray_err_pulse", bus.err, 1);
    @(negedge clock);
    chk("stray_err_one_cycle", bus.err, 0);
    chk("stray_no_valid", bus.out_valid, 0);
    chk("stray_err_count", err_cnt - e0, 1);
    for (int i = 0; i < 8; i++) w[i] = 16'h4100 + 16'(i * 3);
    send_frame(w, 1'b0);
    expect_frame("after_stray");

    // Reset with a pending frame and a partial one in flight
    for (int i = 0; i < 4; i++) send_beat(16'h5000 + 16'(i), i == 0);
    e0 = err_cnt;
    reset = 1'b1;
    #1;
    chk("midrst_lanes", lanes(), 0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_err", bus.err, 0);
    chk("midrst_ready", bus.in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_no_err", err_cnt - e0, 0);
    for (int i = 0; i < 8; i++) w[i] = 16'h6000 + 16'(i);
    send_frame(w, 1'b0);
    expect_frame("after_rst");
    ack();

    // Gapped input
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) w[i] = 16'h1111 * 16'(i + 1);
    send_frame(w, 1'b1);
    expect_frame("gapped");
    chk("gapped_err", err_cnt - e0, 0);
    ack();

    held = lanes();
    @(negedge clock);
    chk("final_lanes_hold", lanes(), held);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tdm_demux8x16.md
TDM_DEMUX8X16 -- requirements
Module: tdm_demux8x16

Interface
REQ-001 The block SHALL have parameter NLANES, default 8, meaning the number of words per frame; only 8 is supported.
REQ-002 The block SHALL have parameter W, default 16, meaning the data word width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in, input, 16 bits: serial word stream, one lane per beat, lane order a..h.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the in and in_sof ports carry a beat.
REQ-007 The block SHALL have port in_sof, input, 1 bit: marks the beat that carries lane a.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-009 The block SHALL have ports a, b, c, d, e, f, g and h, each output, 16 bits: the demultiplexed lanes of the last complete frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the lanes a..h hold an unacknowledged frame.
REQ-011 The block SHALL have port out_ack, input, 1 bit: the consumer has taken the frame.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-013 A beat SHALL be accepted only when in_valid and in_ready are both 1 on the same rising edge.
REQ-014 The FSM SHALL have exactly two states: IDLE (wait for sof) and COLLECT (slot counter 0..7).
REQ-015 In IDLE, an accepted beat with in_sof=1 SHALL be written to shadow slot 0, set slot to 1 and move the FSM to COLLECT.
REQ-016 In IDLE, an accepted beat with in_sof=0 SHALL be discarded and SHALL pulse err for 1 cycle.
REQ-017 In COLLECT, an accepted beat with in_sof=0 SHALL be written to shadow[slot] and increment slot.
REQ-018 In COLLECT, an accepted beat with in_sof=1 at slot!=0 SHALL pulse err, discard the partial frame, write the beat to slot 0 and set slot to 1.
REQ-019 When an accepted beat fills slot 7, shadow slots 0..6 plus that beat SHALL be copied to a..h on the same edge, out_valid SHALL set to 1, slot SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-020 Latency from acceptance of the slot-7 beat to out_valid=1 SHALL be 1 clock.
REQ-021 The lanes a..h SHALL be stable while out_valid=1, except on the edge that delivers a new frame.
REQ-022 out_valid SHALL clear on the edge where out_ack=1, unless a new frame is delivered on that same edge, in which case out_valid SHALL stay 1.
REQ-023 in_ready SHALL be 0 only when the FSM is in COLLECT, slot=7, out_valid=1 and out_ack=0; otherwise in_ready SHALL be 1, combinationally.
REQ-024 out_ack while out_valid=0 SHALL be ignored.
REQ-025 err SHALL be registered and high for exactly one cycle per error event.

Reset
REQ-026 On reset=1, asynchronously: FSM=IDLE, slot=0, shadow=0, a..h=0, out_valid=0, err=0.
REQ-027 After reset, in_ready SHALL be 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no err pulse.
REQ-029 Reset asserted with out_valid=1 SHALL drop the pending frame.

Structure
REQ-030 Constants NLANES=8, W=16, SLOT_W=3 and the state encoding (IDLE=0, COLLECT=1) SHALL live in a shared package, tdm_pkg.
REQ-031 Lane capture SHALL be one sub-module, tdm_lane_reg: a W-bit register with async reset and load enable, instantiated 8 times for the shadow and 8 times for the outputs.
REQ-032 The slot decode SHALL reuse the existing DMux8Way gate to generate the 8 shadow load enables.

Verification
REQ-033 The bench SHALL cover a nominal frame: words 0x1111..0x8888 back-to-back, sof on the first beat -> next cycle a=0x1111 … h=0x8888, out_valid=1, err=0.
REQ-034 The bench SHALL cover backpressure: frame 1 left unacked, frame 2 sent -> in_ready=0 at slot 7; out_ack=1 -> slot-7 beat accepted, a..h update to frame 2, out_valid stays 1.
REQ-035 The bench SHALL cover sof mid-frame: 3 beats, then sof with 0xAAAA, then 7 beats -> err pulses once, a=0xAAAA, the partial frame is never output.
REQ-036 The bench SHALL cover a stray beat: in_valid=1, in_sof=0 in IDLE with 0xDEAD -> err pulse, no out_valid, next sof frame is correct.
REQ-037 The bench SHALL cover reset mid-frame: reset at slot 4 -> all outputs 0, out_valid=0, err=0; next full frame delivered correctly.
REQ-038 The bench SHALL cover gapped input: in_valid toggling 1/0 across a frame -> same result as the nominal frame, latency 1 clock after the last beat.
